pwr_cntr_bank: RTL and testbench

PWR_CNTR_BANK -- requirements
Module: pwr_cntr_bank

---
 rtl/pwr_pkg.sv | 9 +
 rtl/pwr_cntr_cell.sv | 28 ++
 rtl/pwr_cntr_bank.sv | 75 +++++++
 tb/tb_pwr_cntr_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_pkg.sv
// Shared sizing defaults for the power-monitor toggle counter bank.
// The counter bank and any bench that addresses its counters import these values.
package pwr_pkg;

    localparam int unsigned PWR_NUM_CNTR = 5;
    localparam int unsigned PWR_CW       = 32;
    localparam int unsigned PWR_AW       = 3;

endpackage

// File: rtl/pwr_cntr_cell.sv
// One saturating toggle counter.
// It counts cycles where ev differs from its registered copy ev_q while ENB is high.
module pwr_cntr_cell
    import pwr_pkg::*;
#(
    parameter int unsigned CW = PWR_CW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          ENB,
    input  logic          CLR,
    input  logic          ev,
    input  logic          ev_q,
    output logic [CW-1:0] cnt
);

    // Clear wins over a same-cycle increment; all-ones holds instead of wrapping.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (ENB && (ev != ev_q) && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pwr_cntr_bank.sv
// Bank of NUM_CNTR toggle counters with a registered, single-cycle read port.
// An out-of-range address returns zero data and raises ERR.
module pwr_cntr_bank
    import pwr_pkg::*;
#(
    parameter int unsigned NUM_CNTR = PWR_NUM_CNTR,
    parameter int unsigned CW       = PWR_CW,
    parameter int unsigned AW       = PWR_AW
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                ENB,
    input  logic [NUM_CNTR-1:0] EV,
    input  logic                CLR,
    input  logic                RD,
    input  logic [AW-1:0]       dir,
    output logic [CW-1:0]       dato,
    output logic                VLD,
    output logic                ERR
);

    logic [NUM_CNTR-1:0] ev_q;
    logic [CW-1:0]       cnt [NUM_CNTR];
    logic [CW-1:0]       sel_cnt;
    logic                in_range;

    // The EV history is sampled every cycle; ENB and CLR do not affect it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ev_q <= '0;
        end else begin
            ev_q <= EV;
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cell
        pwr_cntr_cell #(.CW(CW)) u_cell (
            .CLK  (CLK),
            .RSTn (RSTn),
            .ENB  (ENB),
            .CLR  (CLR),
            .ev   (EV[g]),
            .ev_q (ev_q[g]),
            .cnt  (cnt[g])
        );
    end

    always_comb begin
        sel_cnt  = '0;
        in_range = (32'(dir) < NUM_CNTR);
        for (int unsigned i = 0; i < NUM_CNTR; i++) begin
            if (dir == AW'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    // Counter values are sampled before the same edge updates them, which gives the read snapshot.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dato <= '0;
            VLD  <= 1'b0;
            ERR  <= 1'b0;
        end else if (RD) begin
            dato <= in_range ? sel_cnt : '0;
            VLD  <= 1'b1;
            ERR  <= ~in_range;
        end else begin
            dato <= '0;
            VLD  <= 1'b0;
            ERR  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwr_cntr_bank.sv
// Bench for pwr_cntr_bank: runs directed scenarios, then random traffic.
// Each DUT output is compared with an integer reference model, for a 32-bit bank and a 4-bit bank.
module tb_pwr_cntr_bank;
    import pwr_pkg::*;

    localparam int unsigned N = PWR_NUM_CNTR;

    logic          CLK  = 1'b0;
    logic          RSTn = 1'b0;
    logic          ENB  = 1'b0;
    logic [N-1:0]  EV   = '0;
    logic          CLR  = 1'b0;
    logic          RD   = 1'b0;
    logic [2:0]    dir  = '0;
    logic [31:0]   dato;
    logic          VLD, ERR;
    logic [3:0]    dato4;
    logic          VLD4, ERR4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    pwr_cntr_bank dut (
        .CLK(CLK), .RSTn(RSTn), .ENB(ENB), .EV(EV), .CLR(CLR),
        .RD(RD), .dir(dir), .dato(dato), .VLD(VLD), .ERR(ERR)
    );

    pwr_cntr_bank #(.CW(4)) dut4 (
        .CLK(CLK), .RSTn(RSTn), .ENB(ENB), .EV(EV), .CLR(CLR),
        .RD(RD), .dir(dir), .dato(dato4), .VLD(VLD4), .ERR(ERR4)
    );

    // Reference model: the count is an integer capped at its limit, and EV history is remembered.
    longint unsigned m_cnt  [N];
    longint unsigned m_cnt4 [N];
    logic [N-1:0]    m_evq;
    logic            m_vld, m_err;
    longint unsigned m_dato, m_dato4;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  <= 0;
                m_cnt4[i] <= 0;
            end
            m_evq  <= '0;
            m_vld  <= 1'b0;
            m_err  <= 1'b0;
            m_dato <= 0;
            m_dato4 <= 0;
        end else begin
            m_vld   <= RD;
            m_err   <= RD && (dir >= N);
            m_dato  <= (RD && dir < N) ? m_cnt[dir]  : 0;
            m_dato4 <= (RD && dir < N) ? m_cnt4[dir] : 0;
            for (int i = 0; i < N; i++) begin
                if (CLR) begin
                    m_cnt[i]  <= 0;
                    m_cnt4[i] <= 0;
                end else if (ENB && EV[i] != m_evq[i]) begin
                    if (m_cnt[i]  < 64'hFFFF_FFFF) m_cnt[i]  <= m_cnt[i] + 1;
                    if (m_cnt4[i] < 15)            m_cnt4[i] <= m_cnt4[i] + 1;
                end
            end
            m_evq <= EV;
        end
    end

    task automatic do_read(input logic [2:0] d, output logic v, output logic [31:0] q,
                           output logic e, output logic [3:0] q4);
        RD  = 1'b1;
        dir = d;
        @(negedge CLK);
        v  = VLD;
        q  = dato;
        e  = ERR;
        q4 = dato4;
        RD = 1'b0;
    endtask

    task automatic toggle(input int bit_i, input int times);
        for (int k = 0; k < times; k++) begin
            EV[bit_i] = ~EV[bit_i];
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b0 || ERR !== 1'b0 || dato !== 32'd0)
            $display("FAIL reset_outputs: VLD=%b ERR=%b dato=%0d required 0/0/0", VLD, ERR, dato);
        else n_pass++;
        RSTn = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            do_read(3'(i), v, q, e, q4);
            n_checks++;
            if (v !== 1'b1 || q !== 32'd0 || e !== 1'b0)
                $display("FAIL reset_cnt%0d: VLD=%b dato=%0d ERR=%b required 1/0/0", i, v, q, e);
            else n_pass++;
        end
    endtask

    task automatic test_toggle();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        ENB = 1'b1;
        toggle(0, 10);
        do_read(3'd0, v, q, e, q4);
        n_checks++;
        if (v !== 1'b1 || q !== 32'd10 || e !== 1'b0)
            $display("FAIL toggle_cnt0: VLD=%b dato=%0d ERR=%b required 1/10/0", v, q, e);
        else n_pass++;
        do_read(3'd1, v, q, e, q4);
        n_checks++;
        if (v !== 1'b1 || q !== 32'd0)
            $display("FAIL toggle_cnt1: VLD=%b dato=%0d required 1/0", v, q);
        else n_pass++;
    endtask

    task automatic test_enable();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        ENB = 1'b0;
        toggle(2, 6);
        ENB = 1'b1;
        toggle(2, 4);
        do_read(3'd2, v, q, e, q4);
        n_checks++;
        if (q !== 32'd4) $display("FAIL enable_gate: dato=%0d required 4", q);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        toggle(1, 3);
        CLR = 1'b1;
        toggle(1, 1);
        CLR = 1'b0;
        do_read(3'd1, v, q, e, q4);
        n_checks++;
        if (q !== 32'd0) $display("FAIL clear_priority: dato=%0d required 0", q);
        else n_pass++;
        do_read(3'd0, v, q, e, q4);
        n_checks++;
        if (q !== 32'd0) $display("FAIL clear_all: dato=%0d required 0", q);
        else n_pass++;
        toggle(1, 1);
        do_read(3'd1, v, q, e, q4);
        n_checks++;
        if (q !== 32'd1) $display("FAIL clear_then_count: dato=%0d required 1", q);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        toggle(3, 7);
        EV[3] = ~EV[3];
        RD  = 1'b1;
        dir = 3'd3;
        @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b1 || dato !== 32'd7)
            $display("FAIL snapshot_pre: VLD=%b dato=%0d required 1/7", VLD, dato);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b1 || dato !== 32'd8)
            $display("FAIL snapshot_post: VLD=%b dato=%0d required 1/8", VLD, dato);
        else n_pass++;
        dir = 3'd6;
        @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b1 || ERR !== 1'b1 || dato !== 32'd0)
            $display("FAIL range_err: VLD=%b ERR=%b dato=%0d required 1/1/0", VLD, ERR, dato);
        else n_pass++;
        RD = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b0 || ERR !== 1'b0 || dato !== 32'd0)
            $display("FAIL idle_outputs: VLD=%b ERR=%b dato=%0d required 0/0/0", VLD, ERR, dato);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        toggle(0, 20);
        do_read(3'd0, v, q, e, q4);
        n_checks++;
        if (q4 !== 4'd15) $display("FAIL saturate_cw4: dato=%0d required 15", q4);
        else n_pass++;
        n_checks++;
        if (q !== 32'd20) $display("FAIL saturate_cw32: dato=%0d required 20", q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        RD = 1'b1;
        for (int k = 0; k < 16; k++) begin
            dir = 3'(k % 8);
            EV  = N'($urandom);
            @(negedge CLK);
            n_checks++;
            if (VLD !== m_vld || ERR !== m_err || 64'(dato) !== m_dato)
                $display("FAIL b2b_%0d: VLD=%b ERR=%b dato=%0d required %b/%b/%0d",
                         k, VLD, ERR, dato, m_vld, m_err, m_dato);
            else n_pass++;
        end
        RD = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            EV  = N'($urandom);
            ENB = ($urandom_range(0, 3) != 0);
            CLR = ($urandom_range(0, 31) == 0);
            RD  = 1'($urandom_range(0, 1));
            dir = 3'($urandom_range(0, 7));
            @(negedge CLK);
            n_checks++;
            if (VLD !== m_vld || ERR !== m_err || 64'(dato) !== m_dato)
                $display("FAIL rand32_%0d: VLD=%b ERR=%b dato=%0d required %b/%b/%0d",
                         k, VLD, ERR, dato, m_vld, m_err, m_dato);
            else n_pass++;
            n_checks++;
            if (VLD4 !== m_vld || ERR4 !== m_err || 64'(dato4) !== m_dato4)
                $display("FAIL rand4_%0d: VLD=%b ERR=%b dato=%0d required %b/%b/%0d",
                         k, VLD4, ERR4, dato4, m_vld, m_err, m_dato4);
            else n_pass++;
        end
        EV = '0; ENB = 1'b1; CLR = 1'b0; RD = 1'b0; dir = '0;
        @(negedge CLK);
    endtask

    task automatic test_async_reset();
        logic v, e; logic [31:0] q; logic [3:0] q4;
        toggle(2, 3);
        RD  = 1'b1;
        dir = 3'd2;
        @(posedge CLK);
        #2 RSTn = 1'b0;
        #1;
        n_checks++;
        if (VLD !== 1'b0 || ERR !== 1'b0 || dato !== 32'd0 || dato4 !== 4'd0)
            $display("FAIL async_reset: VLD=%b ERR=%b dato=%0d required 0/0/0", VLD, ERR, dato);
        else n_pass++;
        RD  = 1'b0;
        EV  = N'(5'b10000);
        ENB = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (VLD !== 1'b0) $display("FAIL no_vld_after_reset: VLD=%b required 0", VLD);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            do_read(3'(i), v, q, e, q4);
            n_checks++;
            if (v !== 1'b1 || q !== ((i == 4) ? 32'd1 : 32'd0))
                $display("FAIL post_reset_cnt%0d: VLD=%b dato=%0d required 1/%0d",
                         i, v, q, (i == 4) ? 1 : 0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_enable();
        test_clear();
        test_snapshot();
        test_saturation();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
